// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - GF(2^m) helpers, FSM state type and root-count helper for the RS syndrome unit
package rs_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } rs_state_e;

    // Number of syndromes (parity roots) for an RS(N,K) code.
    function automatic int rs_nroots(input int n, input int k);
        return n - k;
    endfunction

    // Shift-and-add multiply of a and b in GF(2^m), reduced by poly (which includes the x^m term).
    function automatic int gf_mul(input int a, input int b, input int poly, input int m);
        int p;
        int aa;
        p  = 0;
        aa = a;
        for (int i = 0; i < m; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa << 1;
            if (aa[m]) aa = aa ^ poly;
        end
        return p;
    endfunction

    // alpha^j where alpha = x is the primitive element.
    function automatic int gf_alpha_pow(input int j, input int poly, input int m);
        int p;
        p = 1;
        for (int i = 0; i < j; i++) begin
            p = gf_mul(p, 2, poly, m);
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_syndrome_unit_if.sv
// rtl/rs_syndrome_unit_if.sv - symbol-in / syndrome-out handshake bundle of the RS syndrome unit
interface rs_syndrome_unit_if
    import rs_pkg::*;
#(
    parameter int SYM_W  = 3,
    parameter int NROOTS = rs_nroots(7, 3)
);
    logic                    sym_valid;
    logic                    sym_ready;
    logic [SYM_W-1:0]        sym_data;
    logic                    sym_last;
    logic                    synd_valid;
    logic                    synd_ready;
    logic [NROOTS*SYM_W-1:0] synd;
    logic                    err_det;
    logic                    frame_err;
    logic [15:0]             err_cnt;

    modport master (
        output sym_valid, sym_data, sym_last, synd_ready,
        input  sym_ready, synd_valid, synd, err_det, frame_err, err_cnt
    );

    modport slave (
        input  sym_valid, sym_data, sym_last, synd_ready,
        output sym_ready, synd_valid, synd, err_det, frame_err, err_cnt
    );
endinterface

// File: rtl/rs_gf_const_mul.sv
// rtl/rs_gf_const_mul.sv - combinational multiply by the constant alpha^EXP in GF(2^SYM_W)
module rs_gf_const_mul
    import rs_pkg::*;
#(
    parameter int SYM_W     = 3,
    parameter int PRIM_POLY = 11,
    parameter int EXP       = 1
) (
    input  logic [SYM_W-1:0] a,
    output logic [SYM_W-1:0] y
);
    localparam logic [SYM_W-1:0] COEF = SYM_W'(gf_alpha_pow(EXP, PRIM_POLY, SYM_W));
    localparam logic [SYM_W-1:0] RED  = SYM_W'(PRIM_POLY);

    logic [SYM_W-1:0] sh;

    // Accumulate a*x^i for each set coefficient bit; the constant folds this into an XOR network.
    always_comb begin
        y  = '0;
        sh = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (COEF[i]) y = y ^ sh;
            sh = {sh[SYM_W-2:0], 1'b0} ^ (sh[SYM_W-1] ? RED : '0);
        end
    end
endmodule

// File: rtl/rs_syndrome_unit.sv
// rtl/rs_syndrome_unit.sv - symbol-serial RS syndrome calculator; RS_SYND_ERRCNT_EN adds an errored-codeword counter
module rs_syndrome_unit
    import rs_pkg::*;
#(
    parameter int SYM_W     = 3,
    parameter int N         = 7,
    parameter int K         = 3,
    parameter int PRIM_POLY = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    rs_syndrome_unit_if.slave  bus
);
    localparam int NROOTS = rs_nroots(N, K);
    localparam int CNT_W  = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    rs_state_e               state;
    rs_state_e               state_nxt;
    logic [CNT_W-1:0]        sym_cnt;
    logic [SYM_W-1:0]        s_q      [NROOTS];
    logic [SYM_W-1:0]        s_mul_in [NROOTS];
    logic [SYM_W-1:0]        s_prod   [NROOTS];
    logic [SYM_W-1:0]        s_nxt    [NROOTS];
    logic [NROOTS*SYM_W-1:0] synd_packed;
    logic                    xfer;
    logic                    cw_end;
    logic                    any_nz;
    logic                    err_det_q;
    logic                    frame_err_q;

    assign bus.sym_ready  = (state == ACCUM);
    assign bus.synd_valid = (state == HOLD);
    assign bus.synd       = synd_packed;
    assign bus.err_det    = err_det_q;
    assign bus.frame_err  = frame_err_q;

    assign xfer   = bus.sym_valid && (state == ACCUM);
    assign cw_end = xfer && (bus.sym_last || (sym_cnt == LAST_IDX));

    // One Horner step per root: S_j <- S_j*alpha^j + v, with S_j forced to 0 on the first symbol.
    for (genvar j = 1; j <= NROOTS; j++) begin : g_root
        assign s_mul_in[j-1] = (sym_cnt == '0) ? '0 : s_q[j-1];
        rs_gf_const_mul #(
            .SYM_W     (SYM_W),
            .PRIM_POLY (PRIM_POLY),
            .EXP       (j)
        ) u_mul (
            .a (s_mul_in[j-1]),
            .y (s_prod[j-1])
        );
        assign s_nxt[j-1] = s_prod[j-1] ^ bus.sym_data;
        assign synd_packed[j*SYM_W-1 -: SYM_W] = s_q[j-1];
    end

    // Error detection looks at the syndromes being written on the final transfer.
    always_comb begin
        any_nz = 1'b0;
        for (int j = 0; j < NROOTS; j++) begin
            any_nz = any_nz | (|s_nxt[j]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ACCUM;
        else          state <= state_nxt;
    end

    // Next state: accumulate until codeword end, then hold the result until it is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (cw_end) state_nxt = HOLD;
            HOLD:    if (bus.synd_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Syndrome accumulators, symbol counter and the flags latched at codeword end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_cnt     <= '0;
            err_det_q   <= 1'b0;
            frame_err_q <= 1'b0;
            for (int j = 0; j < NROOTS; j++) s_q[j] <= '0;
        end else begin
            if (xfer) begin
                for (int j = 0; j < NROOTS; j++) s_q[j] <= s_nxt[j];
                sym_cnt <= cw_end ? '0 : sym_cnt + 1'b1;
            end
            if (cw_end) begin
                err_det_q   <= any_nz;
                frame_err_q <= (sym_cnt != LAST_IDX) || !bus.sym_last;
            end
        end
    end

`ifdef RS_SYND_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Count delivered codewords that carried errors, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_cnt_q <= '0;
        else if ((state == HOLD) && bus.synd_ready && err_det_q && (err_cnt_q != 16'hFFFF))
            err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_rs_syndrome_unit.sv
// tb/tb_rs_syndrome_unit.sv - directed bench with polynomial-evaluation model for rs_syndrome_unit
module tb_rs_syndrome_unit;
    localparam int SYM_W     = 3;
    localparam int N         = 7;
    localparam int K         = 3;
    localparam int PRIM_POLY = 11;
    localparam int NROOTS    = N - K;
    localparam int SW        = NROOTS * SYM_W;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rs_syndrome_unit_if #(.SYM_W(SYM_W), .NROOTS(NROOTS)) bus ();

    rs_syndrome_unit #(
        .SYM_W     (SYM_W),
        .N         (N),
        .K         (K),
        .PRIM_POLY (PRIM_POLY)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Carry-less product followed by polynomial long division.
    function automatic int tb_mul(input int a, input int b);
        int r;
        r = 0;
        for (int i = 0; i < SYM_W; i++) if (((b >> i) & 1) != 0) r = r ^ (a << i);
        for (int d = 2 * SYM_W - 2; d >= SYM_W; d--)
            if (((r >> d) & 1) != 0) r = r ^ (PRIM_POLY << (d - SYM_W));
        return r;
    endfunction

    function automatic int tb_pow(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = tb_mul(r, 2);
        return r;
    endfunction

    // Model: collect accepted symbols, evaluate v(alpha^j) = sum v_i * alpha^(j*deg_i) at codeword end.
    int            mq[$];
    logic          m_hold  = 1'b0;
    logic [SW-1:0] m_synd  = '0;
    logic          m_err   = 1'b0;
    logic          m_frame = 1'b0;
    logic [15:0]   m_cnt   = '0;
    int            m_len;
    int            m_acc;
    logic [SW-1:0] m_s;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_hold  <= 1'b0;
            m_synd  <= '0;
            m_err   <= 1'b0;
            m_frame <= 1'b0;
            m_cnt   <= '0;
        end else if (m_hold) begin
            if (bus.synd_ready) begin
                m_hold <= 1'b0;
                if (m_err && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            end
        end else if (bus.sym_valid) begin
            mq.push_back(int'(bus.sym_data));
            if (bus.sym_last || mq.size() == N) begin
                m_len = mq.size();
                m_s   = '0;
                for (int j = 1; j <= NROOTS; j++) begin
                    m_acc = 0;
                    for (int i = 0; i < m_len; i++)
                        m_acc = m_acc ^ tb_mul(mq[i], tb_pow(j * (m_len - 1 - i)));
                    m_s[j*SYM_W-1 -: SYM_W] = m_acc[SYM_W-1:0];
                end
                m_synd  <= m_s;
                m_err   <= (m_s != '0);
                m_frame <= !(bus.sym_last && m_len == N);
                m_hold  <= 1'b1;
                mq.delete();
            end
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        chk("cmp sym_ready", bus.sym_ready, !m_hold);
        chk("cmp synd_valid", bus.synd_valid, m_hold);
        if (m_hold) begin
            chk("cmp synd", bus.synd, m_synd);
            chk("cmp err_det", bus.err_det, m_err);
            chk("cmp frame_err", bus.frame_err, m_frame);
        end
`ifdef RS_SYND_ERRCNT_EN
        chk("cmp err_cnt", bus.err_cnt, m_cnt);
`else
        chk("cmp err_cnt", bus.err_cnt, 0);
`endif
    end

    int cw[N];

    task automatic send_cw(input int n, input int last_pos);
        for (int i = 0; i < n; i++) begin
            int guard;
            bit ok;
            guard = 0;
            ok    = 1'b0;
            bus.sym_valid = 1'b1;
            bus.sym_data  = SYM_W'(cw[i]);
            bus.sym_last  = (i == last_pos);
            while (!ok && guard < 50) begin
                ok = bus.sym_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!ok) chk("send timeout", 0, 1);
        end
        bus.sym_valid = 1'b0;
        bus.sym_last  = 1'b0;
        bus.sym_data  = '0;
    endtask

    task automatic expect_result(input logic [SW-1:0] s, input bit ed, input bit fe, input string tag);
        @(negedge clk);
        chk({tag, " synd_valid"}, bus.synd_valid, 1);
        chk({tag, " synd"}, bus.synd, s);
        chk({tag, " err_det"}, bus.err_det, ed);
        chk({tag, " frame_err"}, bus.frame_err, fe);
        bus.synd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.synd_ready = 1'b0;
        chk({tag, " sym_ready back"}, bus.sym_ready, 1);
    endtask

    task automatic set_cw(input int a0, a1, a2, a3, a4, a5, a6);
        cw[0] = a0; cw[1] = a1; cw[2] = a2; cw[3] = a3;
        cw[4] = a4; cw[5] = a5; cw[6] = a6;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.sym_valid  = 1'b0;
        bus.sym_data   = '0;
        bus.sym_last   = 1'b0;
        bus.synd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset sym_ready", bus.sym_ready, 1);
        chk("reset synd_valid", bus.synd_valid, 0);
        chk("reset synd", bus.synd, 0);
        chk("reset err_det", bus.err_det, 0);
        chk("reset frame_err", bus.frame_err, 0);
        chk("reset err_cnt", bus.err_cnt, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        set_cw(0, 0, 0, 0, 0, 0, 0);
        send_cw(7, 6);
        expect_result(12'h000, 1'b0, 1'b0, "zero");

        set_cw(0, 0, 0, 0, 0, 0, 1);
        send_cw(7, 6);
        expect_result(12'h249, 1'b1, 1'b0, "err_x0");

        set_cw(0, 0, 0, 0, 0, 1, 0);
        send_cw(7, 6);
        expect_result(12'hCE2, 1'b1, 1'b0, "err_x1");

        // Stall in HOLD with a new symbol pending; it must only be taken after the handshake.
        set_cw(1, 2, 3, 4, 5, 6, 7);
        send_cw(7, 6);
        bus.sym_valid = 1'b1;
        bus.sym_data  = 3'd5;
        bus.sym_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall sym_ready", bus.sym_ready, 0);
            chk("stall synd_valid", bus.synd_valid, 1);
        end
        bus.synd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.synd_ready = 1'b0;
        chk("stall resume ready", bus.sym_ready, 1);
        set_cw(5, 0, 0, 0, 0, 0, 0);
        send_cw(7, 6);
        expect_result(12'h8F7, 1'b1, 1'b0, "held");

        set_cw(0, 0, 0, 1, 0, 0, 0);
        send_cw(4, 3);
        expect_result(12'h249, 1'b1, 1'b1, "early_last");

        set_cw(0, 0, 0, 0, 0, 0, 0);
        send_cw(7, -1);
        expect_result(12'h000, 1'b0, 1'b1, "missing_last");

        // Reset part-way through a codeword.
        set_cw(3, 1, 4, 0, 0, 0, 0);
        send_cw(3, -1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset sym_ready", bus.sym_ready, 1);
        chk("midreset synd_valid", bus.synd_valid, 0);
        chk("midreset synd", bus.synd, 0);
        chk("midreset err_det", bus.err_det, 0);
        chk("midreset frame_err", bus.frame_err, 0);
        chk("midreset err_cnt", bus.err_cnt, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_cw(0, 0, 0, 0, 0, 0, 0);
        send_cw(7, 6);
        expect_result(12'h000, 1'b0, 1'b0, "post_reset");

        set_cw(0, 0, 0, 0, 0, 0, 1);
        for (int r = 0; r < 3; r++) begin
            send_cw(7, 6);
            expect_result(12'h249, 1'b1, 1'b0, "cnt_cw");
        end
`ifdef RS_SYND_ERRCNT_EN
        chk("err_cnt after 3", bus.err_cnt, 3);
`else
        chk("err_cnt tied", bus.err_cnt, 0);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
